// File: rtl/trng_capture_if.sv
// Control, capture-memory and UART signals between the TRNG capture controller
// and its surroundings. Clock and reset stay as plain ports on the modules.
interface trng_capture_if #(
    parameter int WORD_WIDTH = 8,
    parameter int AW         = 17
);
    logic                  start;
    logic                  abort;
    logic                  sample_tick;
    logic [WORD_WIDTH-1:0] rng_word;
    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic [AW-1:0]         mem_raddr;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic [7:0]            tx_data;
    logic                  tx_wr_en;
    logic                  tx_busy;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, abort, sample_tick, rng_word, mem_rdata, tx_busy,
        output mem_we, mem_waddr, mem_wdata, mem_raddr, tx_data, tx_wr_en, busy, done
    );

    modport slave (
        output start, abort, sample_tick, rng_word, mem_rdata, tx_busy,
        input  mem_we, mem_waddr, mem_wdata, mem_raddr, tx_data, tx_wr_en, busy, done
    );
endinterface

// File: rtl/trng_capture_controller.sv
// Captures MEM_DEPTH TRNG words into memory, then streams every bit MSB-first
// to the UART as ASCII '0'/'1', one handshaked character at a time.
module trng_capture_controller #(
    parameter int WORD_WIDTH = 8,
    parameter int BIT_COUNT  = 1000000
) (
    input  logic           clock,
    input  logic           reset_n,
    trng_capture_if.master bus
);
    localparam int MEM_DEPTH = BIT_COUNT / WORD_WIDTH;
    localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int BW        = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_WIDTH - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CAPTURE = 3'd1;
    localparam logic [2:0] TX_SEND = 3'd2;
    localparam logic [2:0] TX_ACK  = 3'd3;
    localparam logic [2:0] TX_WAIT = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [BW-1:0]   bit_idx_q, bit_idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            char_rdy_q, char_rdy_d;
    logic            start_q, start_d;
    logic            done_q, done_d;
    logic            write_en;
    logic            send_strobe;
    logic            start_edge;

    assign start_edge = bus.start & ~start_q;

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        bit_idx_d   = bit_idx_q;
        tx_data_d   = tx_data_q;
        char_rdy_d  = char_rdy_q;
        start_d     = bus.start;
        done_d      = 1'b0;
        write_en    = 1'b0;
        send_strobe = 1'b0;

        if (bus.abort) begin
            state_d    = IDLE;
            waddr_d    = '0;
            raddr_d    = '0;
            bit_idx_d  = '0;
            char_rdy_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d = CAPTURE;
                        waddr_d = '0;
                    end
                end
                CAPTURE: begin
                    if (bus.sample_tick) begin
                        write_en = 1'b1;
                        if (waddr_q == LAST_ADDR) begin
                            state_d    = TX_SEND;
                            waddr_d    = '0;
                            raddr_d    = '0;
                            bit_idx_d  = '0;
                            char_rdy_d = 1'b0;
                        end else begin
                            waddr_d = waddr_q + AW'(1);
                        end
                    end
                end
                TX_SEND: begin
                    // First cycle registers the character, second cycle strobes it,
                    // so the strobe always lines up with a stable registered tx_data.
                    if (!char_rdy_q) begin
                        tx_data_d  = bus.mem_rdata[LAST_BIT - bit_idx_q] ? 8'h31 : 8'h30;
                        char_rdy_d = 1'b1;
                    end else if (!bus.tx_busy) begin
                        send_strobe = 1'b1;
                        char_rdy_d  = 1'b0;
                        state_d     = TX_ACK;
                    end
                end
                TX_ACK: begin
                    if (bus.tx_busy) state_d = TX_WAIT;
                end
                TX_WAIT: begin
                    if (!bus.tx_busy) begin
                        if (bit_idx_q != LAST_BIT) begin
                            bit_idx_d = bit_idx_q + BW'(1);
                            state_d   = TX_SEND;
                        end else begin
                            bit_idx_d = '0;
                            if (raddr_q != LAST_ADDR) begin
                                raddr_d = raddr_q + AW'(1);
                                state_d = TX_SEND;
                            end else begin
                                raddr_d = '0;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            waddr_q    <= '0;
            raddr_q    <= '0;
            bit_idx_q  <= '0;
            tx_data_q  <= 8'h30;
            char_rdy_q <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            bit_idx_q  <= bit_idx_d;
            tx_data_q  <= tx_data_d;
            char_rdy_q <= char_rdy_d;
            start_q    <= start_d;
            done_q     <= done_d;
        end
    end

    assign bus.mem_we    = write_en;
    assign bus.mem_waddr = waddr_q;
    assign bus.mem_wdata = bus.rng_word;
    assign bus.mem_raddr = raddr_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_wr_en  = send_strobe;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_trng_capture_controller.sv
// Directed/randomized bench for trng_capture_controller with a small memory,
// a UART busy model and a bit-stream reference built from the captured words.
module tb_trng_capture_controller;
    localparam int W  = 8;
    localparam int BC = 32;
    localparam int MD = BC / W;
    localparam int AW = (MD > 1) ? $clog2(MD) : 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    trng_capture_if #(.WORD_WIDTH(W), .AW(AW)) bus ();

    trng_capture_controller #(.WORD_WIDTH(W), .BIT_COUNT(BC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // capture memory, combinational read
    logic [W-1:0] tmem [MD];
    always @(posedge clock) if (bus.mem_we) tmem[bus.mem_waddr] <= bus.mem_wdata;
    assign bus.mem_rdata = tmem[bus.mem_raddr];

    // UART: busy from the cycle after the strobe, for uart_hold cycles
    int uart_hold = 10;
    int busy_cnt  = 0;
    always @(posedge clock) begin
        if (bus.tx_wr_en)   busy_cnt <= uart_hold;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt > 0);

    // monitors sample on the falling edge
    logic [AW-1:0] wr_addr [$];
    logic [W-1:0]  wr_data [$];
    logic [7:0]    chars   [$];
    int done_cnt, done_bad, wr_busy_bad, we_bad;
    logic prev_busy = 1'b0, prev_done = 1'b0;
    always @(negedge clock) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_waddr);
            wr_data.push_back(bus.mem_wdata);
            if (!bus.sample_tick) we_bad++;
        end
        if (bus.tx_wr_en) begin
            chars.push_back(bus.tx_data);
            if (bus.tx_busy) wr_busy_bad++;
        end
        if (bus.done) begin
            done_cnt++;
            if (bus.busy || !prev_busy || prev_done) done_bad++;
        end
        prev_busy = bus.busy;
        prev_done = bus.done;
    end

    int checks = 0;
    int errors = 0;
    logic [W-1:0] words [MD];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete(); wr_data.delete(); chars.delete();
        done_cnt = 0; done_bad = 0; wr_busy_bad = 0; we_bad = 0;
    endtask

    task automatic new_words();
        for (int i = 0; i < MD; i++) words[i] = W'($urandom);
    endtask

    task automatic capture(input int gap, input bit hold_start);
        bus.start = 1'b1;
        step();
        if (!hold_start) bus.start = 1'b0;
        for (int i = 0; i < MD; i++) begin
            repeat (gap) step();
            bus.sample_tick = 1'b1;
            bus.rng_word    = words[i];
            step();
            bus.sample_tick = 1'b0;
            bus.rng_word    = W'($urandom);
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, int'(done_cnt > 0), 1);
    endtask

    // reference: the expected stream is each word's bits, MSB first, as ASCII
    task automatic check_run(input string tag);
        int bad;
        logic [7:0] exp_c;
        check({tag, "_nwrites"}, wr_addr.size(), MD);
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < MD; i++)
            if (int'(wr_addr[i]) != i || wr_data[i] !== words[i]) bad++;
        check({tag, "_write_seq"}, bad, 0);
        check({tag, "_nchars"}, chars.size(), BC);
        bad = 0;
        for (int i = 0; i < chars.size() && i < BC; i++) begin
            exp_c = words[i / W][W - 1 - (i % W)] ? 8'h31 : 8'h30;
            if (chars[i] !== exp_c) bad++;
        end
        check({tag, "_char_stream"}, bad, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_shape"}, done_bad, 0);
        check({tag, "_wr_while_busy"}, wr_busy_bad, 0);
        check({tag, "_we_off_tick"}, we_bad, 0);
    endtask

    initial begin
        int n;
        bus.start = 1'b0; bus.abort = 1'b0; bus.sample_tick = 1'b1; bus.rng_word = '0;
        clear_mon();
        repeat (3) step();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_wr_en", int'(bus.tx_wr_en), 0);
        check("rst_tx_data", int'(bus.tx_data), 'h30);
        check("rst_waddr", int'(bus.mem_waddr), 0);
        check("rst_raddr", int'(bus.mem_raddr), 0);
        reset_n = 1'b1;
        step();
        check("idle_tick_no_we", int'(bus.mem_we), 0);
        bus.sample_tick = 1'b0;
        step();

        // basic run with the fixed pattern
        clear_mon();
        words[0] = 8'hA5; words[1] = 8'h00; words[2] = 8'hFF; words[3] = 8'h3C;
        capture(0, 1'b0);
        wait_done("basic", 3000);
        check_run("basic");
        check("basic_first_char", (chars.size() > 0) ? int'(chars[0]) : -1, 'h31);

        // spaced ticks, plus ticks after capture that must be ignored
        repeat (5) step();
        clear_mon();
        new_words();
        capture(4, 1'b0);
        repeat (3) begin
            bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0; step();
        end
        wait_done("spaced", 3000);
        check_run("spaced");

        // slow UART: long busy after every accept
        repeat (5) step();
        clear_mon();
        uart_hold = 50;
        new_words();
        capture(1, 1'b0);
        wait_done("slow_uart", 5000);
        check_run("slow_uart");
        uart_hold = 10;

        // abort while waiting on character 10
        repeat (60) step();
        clear_mon();
        new_words();
        capture(0, 1'b0);
        n = 0;
        while (chars.size() < 10 && n < 2000) begin step(); n++; end
        check("abort_reach_char10", chars.size(), 10);
        n = 0;
        while (!bus.tx_busy && n < 50) begin step(); n++; end
        step(); step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_raddr", int'(bus.mem_raddr), 0);
        check("abort_wr_en", int'(bus.tx_wr_en), 0);
        repeat (40) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_more_chars", chars.size(), 10);
        clear_mon();
        new_words();
        capture(2, 1'b0);
        wait_done("after_abort", 3000);
        check_run("after_abort");

        // start held high and re-pulsed mid-run
        repeat (5) step();
        clear_mon();
        new_words();
        capture(0, 1'b1);
        repeat (100) step();
        bus.start = 1'b0; step(); bus.start = 1'b1;
        wait_done("held_start", 3000);
        repeat (200) step();
        check("held_start_idle", int'(bus.busy), 0);
        check_run("held_start");
        bus.start = 1'b0;
        step();

        // async reset mid-capture
        clear_mon();
        new_words();
        bus.start = 1'b1; step(); bus.start = 1'b0;
        bus.sample_tick = 1'b1; bus.rng_word = words[0]; step();
        bus.rng_word = words[1]; step();
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("arst_busy", int'(bus.busy), 0);
        check("arst_mem_we", int'(bus.mem_we), 0);
        check("arst_waddr", int'(bus.mem_waddr), 0);
        check("arst_tx_data", int'(bus.tx_data), 'h30);
        check("arst_done", int'(bus.done), 0);
        bus.sample_tick = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (15) step();
        clear_mon();
        new_words();
        capture(1, 1'b0);
        wait_done("post_reset", 3000);
        check_run("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
